// File: rtl/chacha_state_gen.sv
// ChaCha20 initial-state generator: expands one key/nonce/counter configuration into
// a stream of 4x4 block states, LANES consecutive blocks per output beat.
module chacha_state_gen #(
  parameter int unsigned LANES = 1,
  parameter int unsigned CTR_W = 32,
  parameter int unsigned NB_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [7:0][31:0]              key,
  input  logic [127-CTR_W:0]            nonce,
  input  logic [CTR_W-1:0]              ctr_init,
  input  logic [NB_W-1:0]               num_blocks,
  input  logic                          abort,
  output logic                          st_valid,
  input  logic                          st_ready,
  output logic [LANES-1:0][15:0][31:0]  st_data,
  output logic [CTR_W-1:0]              st_ctr,
  output logic [LANES-1:0]              st_lane_en,
  output logic                          st_last,
  output logic                          busy,
  output logic                          ctr_ovf
);

  localparam int unsigned NONCE_WORDS = (128 - CTR_W) / 32;
  localparam int unsigned CTR_WORDS   = CTR_W / 32;
  // Wide enough to hold ctr_init + num_blocks - 1 without losing the carry.
  localparam int unsigned SUM_W       = ((CTR_W > NB_W) ? CTR_W : NB_W) + 1;
  localparam int unsigned REM_W       = NB_W + 4;
  localparam logic [REM_W-1:0] LANES_C = REM_W'(LANES);
  localparam logic [3:0][31:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

  if (!(CTR_W == 32 || CTR_W == 64)) begin : gen_bad_ctr_w
    $error("chacha_state_gen: CTR_W must be 32 or 64");
  end
  if (LANES < 1 || LANES > 8) begin : gen_bad_lanes
    $error("chacha_state_gen: LANES must be 1..8");
  end

  typedef enum logic [0:0] {StIdle, StGen} state_e;

  state_e                  state_q, state_d;
  logic [7:0][31:0]        key_q, key_d;
  logic [127-CTR_W:0]      nonce_q, nonce_d;
  logic [CTR_W-1:0]        ctr_q, ctr_d;
  logic [NB_W-1:0]         rem_q, rem_d;
  logic                    ovf_q, ovf_d;

  logic [SUM_W-1:0]        end_ctr;
  logic                    wrap;
  logic [REM_W-1:0]        ext_rem;
  logic                    last_beat;
  logic [CTR_W-1:0]        lane_ctr;

  // Counter of the final requested block; any bit above CTR_W means an enabled lane would wrap.
  assign end_ctr   = SUM_W'(ctr_init) + SUM_W'(num_blocks) - SUM_W'(1);
  assign wrap      = |end_ctr[SUM_W-1:CTR_W];
  assign ext_rem   = {4'b0000, rem_q};
  assign last_beat = (ext_rem <= LANES_C);

  assign cfg_ready = (state_q == StIdle);
  assign busy      = (state_q == StGen);
  assign st_valid  = busy;
  assign ctr_ovf   = ovf_q;

  // Next-state: config latch and wrap check in idle, counter/remaining update per accepted beat.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    nonce_d = nonce_q;
    ctr_d   = ctr_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          key_d   = key;
          nonce_d = nonce;
          ctr_d   = ctr_init;
          rem_d   = num_blocks;
          ovf_d   = 1'b0;
          if (num_blocks != '0) begin
            if (wrap) ovf_d = 1'b1;
            else      state_d = StGen;
          end
        end
      end
      StGen: begin
        if (abort) begin
          state_d = StIdle;
        end else if (st_ready) begin
          ctr_d = ctr_q + CTR_W'(LANES);
          if (last_beat) begin
            rem_d   = '0;
            state_d = StIdle;
          end else begin
            // rem_q > LANES here, so LANES fits in NB_W bits.
            rem_d = rem_q - LANES_C[NB_W-1:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Beat assembly from latched config; everything reads zero outside GEN.
  always_comb begin
    st_data    = '0;
    st_ctr     = '0;
    st_lane_en = '0;
    st_last    = 1'b0;
    lane_ctr   = '0;
    if (state_q == StGen) begin
      st_ctr  = ctr_q;
      st_last = last_beat;
      for (int i = 0; i < int'(LANES); i++) begin
        lane_ctr       = ctr_q + CTR_W'(i);
        st_lane_en[i]  = (ext_rem > REM_W'(i));
        st_data[i][3:0] = SIGMA;
        for (int k = 0; k < 8; k++) begin
          st_data[i][4+k] = key_q[k];
        end
        for (int j = 0; j < int'(CTR_WORDS); j++) begin
          st_data[i][12+j] = lane_ctr[32*j +: 32];
        end
        for (int k = 0; k < int'(NONCE_WORDS); k++) begin
          st_data[i][12+CTR_WORDS+k] = nonce_q[32*k +: 32];
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      key_q   <= '0;
      nonce_q <= '0;
      ctr_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      nonce_q <= nonce_d;
      ctr_q   <= ctr_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_chacha_state_gen.sv
// Directed bench for chacha_state_gen: three instances (4-lane/32-bit counter,
// 1-lane/32-bit counter, 1-lane/64-bit counter) checked against a beat scoreboard.
module tb_chacha_state_gen;

  localparam logic [127:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

  typedef struct packed {
    logic [63:0] ctr;
    logic [3:0]  len;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0][31:0] key;
  logic [15:0] nb;
  logic st_ready, abort;
  logic [95:0] nonce_a;
  logic [31:0] ctr_a;
  logic [63:0] nonce_c;
  logic [63:0] ctr_c;
  logic cfg_a, cfg_b, cfg_c;

  logic a_rdy, a_valid, a_last, a_busy, a_ovf;
  logic [3:0][15:0][31:0] a_data;
  logic [31:0] a_ctr;
  logic [3:0] a_len;

  logic b_rdy, b_valid, b_last, b_busy, b_ovf;
  logic [0:0][15:0][31:0] b_data;
  logic [31:0] b_ctr;
  logic [0:0] b_len;

  logic c_rdy, c_valid, c_last, c_busy, c_ovf;
  logic [0:0][15:0][31:0] c_data;
  logic [63:0] c_ctr;
  logic [0:0] c_len;

  beat_t q_a[$], q_b[$], q_c[$];
  logic [7:0][31:0] exp_key;
  logic [95:0] exp_nonce_a, exp_nonce_b;
  logic [63:0] exp_nonce_c;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  chacha_state_gen #(.LANES(4), .CTR_W(32), .NB_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_a), .cfg_ready(a_rdy), .key(key),
    .nonce(nonce_a), .ctr_init(ctr_a), .num_blocks(nb), .abort(abort),
    .st_valid(a_valid), .st_ready(st_ready), .st_data(a_data), .st_ctr(a_ctr),
    .st_lane_en(a_len), .st_last(a_last), .busy(a_busy), .ctr_ovf(a_ovf)
  );

  chacha_state_gen #(.LANES(1), .CTR_W(32), .NB_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_b), .cfg_ready(b_rdy), .key(key),
    .nonce(nonce_a), .ctr_init(ctr_a), .num_blocks(nb), .abort(abort),
    .st_valid(b_valid), .st_ready(st_ready), .st_data(b_data), .st_ctr(b_ctr),
    .st_lane_en(b_len), .st_last(b_last), .busy(b_busy), .ctr_ovf(b_ovf)
  );

  chacha_state_gen #(.LANES(1), .CTR_W(64), .NB_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_c), .cfg_ready(c_rdy), .key(key),
    .nonce(nonce_c), .ctr_init(ctr_c), .num_blocks(nb), .abort(abort),
    .st_valid(c_valid), .st_ready(st_ready), .st_data(c_data), .st_ctr(c_ctr),
    .st_lane_en(c_len), .st_last(c_last), .busy(c_busy), .ctr_ovf(c_ovf)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat_a(input bit do_pop);
    beat_t e;
    if (q_a.size() == 0) begin
      check("a_unexpected_beat", a_valid, 1'b0);
      return;
    end
    e = q_a[0];
    if (do_pop) void'(q_a.pop_front());
    check("a_ctr", a_ctr, e.ctr[31:0]);
    check("a_lane_en", a_len, e.len);
    check("a_last", a_last, e.last);
    for (int i = 0; i < 4; i++) begin
      if (e.len[i]) check("a_lane", a_data[i], {exp_nonce_a, e.ctr[31:0] + 32'(i), exp_key, SIGMA});
    end
  endtask

  task automatic check_beat_b();
    beat_t e;
    if (q_b.size() == 0) begin
      check("b_unexpected_beat", b_valid, 1'b0);
      return;
    end
    e = q_b.pop_front();
    check("b_ctr", b_ctr, e.ctr[31:0]);
    check("b_lane_en", b_len, e.len[0]);
    check("b_last", b_last, e.last);
    check("b_lane", b_data[0], {exp_nonce_b, e.ctr[31:0], exp_key, SIGMA});
  endtask

  task automatic check_beat_c();
    beat_t e;
    if (q_c.size() == 0) begin
      check("c_unexpected_beat", c_valid, 1'b0);
      return;
    end
    e = q_c.pop_front();
    check("c_ctr", c_ctr, e.ctr);
    check("c_last", c_last, e.last);
    check("c_w12", b_word(c_data[0], 12), e.ctr[31:0]);
    check("c_w13", b_word(c_data[0], 13), e.ctr[63:32]);
    check("c_lane", c_data[0], {exp_nonce_c, e.ctr, exp_key, SIGMA});
  endtask

  function automatic logic [31:0] b_word(input logic [15:0][31:0] lane, input int idx);
    return lane[idx];
  endfunction

  // Inputs are set at the negedge; a handshake seen here completes at the coming posedge.
  task automatic tick();
    if (rst_n && st_ready && !abort) begin
      if (a_valid) check_beat_a(1'b1);
      if (b_valid) check_beat_b();
      if (c_valid) check_beat_c();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input string which, input logic [63:0] c, input logic [3:0] l,
                      input logic last);
    beat_t e;
    e.ctr = c;
    e.len = l;
    e.last = last;
    if (which == "a") q_a.push_back(e);
    else if (which == "b") q_b.push_back(e);
    else q_c.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_a = 1'b0; cfg_b = 1'b0; cfg_c = 1'b0;
    abort = 1'b0; st_ready = 1'b0; nb = '0;
    nonce_a = '0; nonce_c = '0; ctr_a = '0; ctr_c = '0;
    for (int i = 0; i < 8; i++) key[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    exp_key = key;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_valid", a_valid, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_ovf", a_ovf, 1'b0);
    check("rst_last", a_last, 1'b0);
    check("rst_data", a_data, 512'h0);
    check("rst_ctr", a_ctr, 32'h0);
    check("rst_lane_en", a_len, 4'h0);
    check("rst_cfg_ready", a_rdy, 1'b1);
    check("rst_c_data", c_data, 512'h0);
    rst_n = 1'b1;
    tick();

    // RFC 8439 2.3.2 block setup on the single-lane instance
    nonce_a = 96'h00000000_4a000000_09000000;
    exp_nonce_b = nonce_a;
    ctr_a = 32'h1; nb = 16'd1; st_ready = 1'b1; cfg_b = 1'b1;
    push("b", 64'h1, 4'b0001, 1'b1);
    check("b_w12_pre", b_valid, 1'b0);
    tick();
    cfg_b = 1'b0;
    check("b_valid_latency", b_valid, 1'b1);
    check("b_w12", b_word(b_data[0], 12), 32'h00000001);
    check("b_w13", b_word(b_data[0], 13), 32'h09000000);
    check("b_w14", b_word(b_data[0], 14), 32'h4a000000);
    check("b_w15", b_word(b_data[0], 15), 32'h00000000);
    check("b_w4", b_word(b_data[0], 4), 32'h03020100);
    tick();
    check("b_idle_after", b_valid, 1'b0);
    check("b_busy_after", b_busy, 1'b0);

    // Four lanes, six blocks; key input changes after accept must not leak out
    exp_nonce_a = nonce_a;
    ctr_a = 32'h0; nb = 16'd6; cfg_a = 1'b1;
    push("a", 64'd0, 4'b1111, 1'b0);
    push("a", 64'd4, 4'b0011, 1'b1);
    tick();
    cfg_a = 1'b0;
    key = ~key;
    check("a_busy_gen", a_busy, 1'b1);
    check("a_cfg_ready_gen", a_rdy, 1'b0);
    tick();
    tick();
    check("a_idle_after2", a_valid, 1'b0);
    key = exp_key;

    // Backpressure for five cycles on the second beat
    ctr_a = 32'd100; nb = 16'd12; cfg_a = 1'b1;
    push("a", 64'd100, 4'b1111, 1'b0);
    push("a", 64'd104, 4'b1111, 1'b0);
    push("a", 64'd108, 4'b1111, 1'b1);
    tick();
    cfg_a = 1'b0;
    tick();
    st_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      check("a_stall_valid", a_valid, 1'b1);
      check_beat_a(1'b0);
    end
    st_ready = 1'b1;
    tick();
    tick();
    check("a_idle_after3", a_valid, 1'b0);

    // Wrap rejection, then the largest legal job at the top of the counter space
    ctr_a = 32'hFFFF_FFFE; nb = 16'd3; cfg_b = 1'b1;
    tick();
    cfg_b = 1'b0;
    check("b_ovf_set", b_ovf, 1'b1);
    check("b_ovf_novalid", b_valid, 1'b0);
    tick();
    check("b_ovf_novalid2", b_valid, 1'b0);
    nb = 16'd2; cfg_b = 1'b1;
    push("b", 64'hFFFF_FFFE, 4'b0001, 1'b0);
    push("b", 64'hFFFF_FFFF, 4'b0001, 1'b1);
    tick();
    cfg_b = 1'b0;
    check("b_ovf_clear", b_ovf, 1'b0);
    tick();
    tick();
    check("b_idle_after4", b_valid, 1'b0);

    // num_blocks == 0 produces nothing
    nb = 16'd0; cfg_a = 1'b1;
    tick();
    cfg_a = 1'b0;
    check("a_nb0_valid", a_valid, 1'b0);

    // 64-bit counter carrying into the high word
    nonce_c = 64'h89ab_cdef_0123_4567;
    exp_nonce_c = nonce_c;
    ctr_c = 64'h0000_0000_FFFF_FFFF; nb = 16'd2; cfg_c = 1'b1;
    push("c", 64'h0000_0000_FFFF_FFFF, 4'b0001, 1'b0);
    push("c", 64'h0000_0001_0000_0000, 4'b0001, 1'b1);
    tick();
    cfg_c = 1'b0;
    tick();
    tick();
    check("c_idle_after", c_valid, 1'b0);

    // Abort on the second beat of a ten-block job; the concurrent handshake is dropped
    ctr_a = 32'd0; nb = 16'd10; cfg_a = 1'b1;
    push("a", 64'd0, 4'b1111, 1'b0);
    tick();
    cfg_a = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("a_abort_valid", a_valid, 1'b0);
    check("a_abort_busy", a_busy, 1'b0);
    check("a_abort_ready", a_rdy, 1'b1);

    // Abort in idle is ignored and the concurrent config is taken
    ctr_a = 32'd7; nb = 16'd1; cfg_a = 1'b1; abort = 1'b1;
    push("a", 64'd7, 4'b0001, 1'b1);
    tick();
    cfg_a = 1'b0; abort = 1'b0;
    check("a_idle_abort_accept", a_valid, 1'b1);
    tick();

    // Reset mid-job
    ctr_a = 32'd0; nb = 16'd10; cfg_a = 1'b1;
    push("a", 64'd0, 4'b1111, 1'b0);
    tick();
    cfg_a = 1'b0;
    tick();
    rst_n = 1'b0; st_ready = 1'b0;
    tick();
    check("mrst_valid", a_valid, 1'b0);
    check("mrst_busy", a_busy, 1'b0);
    check("mrst_data", a_data, 512'h0);
    check("mrst_ctr", a_ctr, 32'h0);
    check("mrst_lane_en", a_len, 4'h0);
    check("mrst_last", a_last, 1'b0);
    rst_n = 1'b1; st_ready = 1'b1;
    tick();
    check("mrst_stays_idle", a_valid, 1'b0);

    check("a_sb_empty", q_a.size(), 0);
    check("b_sb_empty", q_b.size(), 0);
    check("c_sb_empty", q_c.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
